// File: rtl/mult_shift_add.sv
// rtl/mult_shift_add.sv - sequential shift-and-add unsigned multiplier (IDLE/RUN/DONE FSM)
// Optional early termination when the remaining multiplier is zero: define MULT_EARLY_EXIT_EN.
`timescale 1ns/1ps

module mult_shift_add #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] pp,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] pp_q, pp_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mult_q, mult_d;
  logic [CW-1:0]  count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pp_q    <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pp_q    <= pp_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pp_d    = pp_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (init) begin
          mcand_d = {{N{1'b0}}, A};
          mult_d  = B;
          pp_d    = '0;
          count_d = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        // The product fits in 2N bits, so the accumulate never carries out.
        if (mult_q[0]) pp_d = pp_q + mcand_q;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = DONE;
`ifdef MULT_EARLY_EXIT_EN
        if ((mult_q >> 1) == '0) state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pp   = pp_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: doc/mult_shift_add.md
MULT_SHIFT_ADD -- requirements
Module: mult_shift_add

Interface
REQ-001 Parameter: N, default 8, operand width in bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 init  input  1  start request; sampled only in IDLE.
REQ-005 A  input  N  multiplicand, unsigned.
REQ-006 B  input  N  multiplier, unsigned.
REQ-007 pp  output  2N  product accumulator; valid only when done=1; held until the next accepted init.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse marking pp valid.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE, with no other reachable state.
REQ-011 IDLE, init=1: latch mcand={N'b0,A}, latch mult=B, clear pp to 0, load count=N, go to RUN.
REQ-012 IDLE, init=0: hold all registers; pp keeps its last result.
REQ-013 RUN, every cycle: if mult[0]=1 then pp<=pp+mcand (2N-bit add, no carry-out possible); mcand<<=1; mult>>=1; count<=count-1.
REQ-014 RUN->DONE when count=1 at the clock edge; otherwise remain in RUN, so RUN lasts exactly N cycles.
REQ-015 DONE: done=1 for exactly one cycle, pp holds A*B, then unconditionally go to IDLE.
REQ-016 Latency: init sampled at edge 0 -> done high in the cycle following edge N+1; next init accepted at edge N+2 at the earliest.
REQ-017 init while busy=1, including during the DONE cycle, SHALL be ignored with no queuing.
REQ-018 A and B SHALL be sampled only at acceptance; later changes SHALL NOT affect the running product.
REQ-019 The result SHALL equal the exact unsigned product for all operand pairs, including 0 and 2^N-1.

Reset
REQ-020 rst=1 at a clock edge: state=IDLE, pp=0, done=0, busy=0, count=0, mcand=0, mult=0.
REQ-021 rst SHALL have priority over init and over every FSM transition.
REQ-022 rst during RUN or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-023 The macro MULT_EARLY_EXIT_EN SHALL control early termination.
REQ-024 With MULT_EARLY_EXIT_EN defined: RUN->DONE also when the shifted mult value is 0, so RUN lasts R = max(1, index of the highest set bit of B + 1) cycles.
REQ-025 With MULT_EARLY_EXIT_EN defined: done is high in the cycle following edge R+1, and pp is identical to the non-early-exit result.
REQ-026 Without MULT_EARLY_EXIT_EN: the fixed N-cycle RUN of REQ-014 applies, and no zero-detect logic is synthesized.

Verification (N=8)
REQ-027 A=255, B=255, init pulse -> done one cycle after edge 9, pp=65025, busy high for 9 cycles.
REQ-028 A=13, B=11 -> pp=143; A=0, B=200 -> pp=0; A=200, B=0 -> pp=0; each done exactly once.
REQ-029 Start A=7, B=9, then hold init=1 and A=3, B=3 throughout RUN -> pp=63, and a second operation starts only at or after edge 10.
REQ-030 Start A=100, B=100, assert rst at edge 4 -> pp=0, busy=0, no done pulse; a new init of A=2, B=3 -> pp=6.
REQ-031 With MULT_EARLY_EXIT_EN: A=200, B=1 -> done one cycle after edge 2, pp=200; B=0 -> done one cycle after edge 2, pp=0; B=128 -> done one cycle after edge 9.
REQ-032 Random run of 1000 operand pairs, built with and without the macro -> every pp equals the reference product A*B.
